// File: rtl/taxi_axis_demux_mcast_pkg.sv
// rtl/taxi_axis_demux_mcast_pkg.sv - shared types and helpers for the multicast demux
package taxi_axis_demux_mcast_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

  // Index decode for tdest routing; an out-of-range index selects nothing.
  function automatic logic [31:0] onehot_idx(input logic [31:0] idx, input int m_count);
    onehot_idx = '0;
    if (idx < 32'(m_count)) onehot_idx[idx[4:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/taxi_axis_demux_mcast_if.sv
// rtl/taxi_axis_demux_mcast_if.sv - AXI4-Stream interface with source/sink modports
interface taxi_axis_if #(
  parameter int DATA_W  = 8,
  parameter int KEEP_W  = 1,
  parameter int ID_W    = 8,
  parameter int DEST_W  = 8,
  parameter int USER_W  = 1,
  parameter bit LAST_EN = 1'b1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport src (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, input tready);
  modport snk (input tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, output tready);
endinterface

// File: rtl/taxi_axis_demux_mcast_oreg.sv
// rtl/taxi_axis_demux_mcast_oreg.sv - one-beat output register with load/drain valid tracking
module taxi_axis_demux_mcast_oreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  // A load on the same cycle as a drain keeps valid high with the new beat.
  always_ff @(posedge clk) begin
    if (load) dout <= din;
    if (rst) valid <= 1'b0;
    else if (load) valid <= 1'b1;
    else if (ready) valid <= 1'b0;
  end

endmodule

// File: rtl/taxi_axis_demux_mcast.sv
// rtl/taxi_axis_demux_mcast.sv - multicast AXI4-Stream demux, route latched per frame
module taxi_axis_demux_mcast
  import taxi_axis_demux_mcast_pkg::*;
#(
  parameter int   M_COUNT     = 4,
  parameter logic TDEST_ROUTE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  taxi_axis_if.snk           s_axis,
  taxi_axis_if.src           m_axis [M_COUNT],
  input  logic               enable,
  input  logic               drop,
  input  logic [M_COUNT-1:0] select_mask,
  output logic               stat_drop,
  output logic               busy
);

  localparam int DATA_W   = s_axis.DATA_W;
  localparam int KEEP_W   = s_axis.KEEP_W;
  localparam int ID_W     = s_axis.ID_W;
  localparam int USER_W   = s_axis.USER_W;
  localparam int S_DEST_W = s_axis.DEST_W;
  localparam bit LAST_EN  = s_axis.LAST_EN;
  localparam int SEL_W    = M_COUNT > 1 ? $clog2(M_COUNT) : 1;
  localparam int M_DEST_W = S_DEST_W - SEL_W;
  localparam int W        = DATA_W + 2 * KEEP_W + 1 + ID_W + USER_W + M_DEST_W;

  state_t             state, state_next;
  logic [M_COUNT-1:0] mask_reg, mask_next, dec_mask, route_mask;
  logic [M_COUNT-1:0] out_valid, out_ready, load;
  logic [SEL_W-1:0]   sel_idx;
  logic               decide, route_drop, s_ready, accept, last_beat, drop_pulse;
  logic [W-1:0]       beat;

  assign sel_idx   = s_axis.tdest[S_DEST_W-1 -: SEL_W];
  assign dec_mask  = TDEST_ROUTE ? M_COUNT'(onehot_idx(32'(sel_idx), M_COUNT)) : select_mask;
  assign last_beat = LAST_EN ? s_axis.tlast : 1'b1;
  assign beat      = {s_axis.tdata, s_axis.tkeep, s_axis.tstrb, last_beat,
                      s_axis.tid, s_axis.tuser, s_axis.tdest[M_DEST_W-1:0]};

  always_comb begin
    state_next = state;
    mask_next  = mask_reg;
    route_mask = '0;
    route_drop = 1'b0;
    decide     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axis.tvalid && enable) begin
          decide     = 1'b1;
          route_drop = drop || (dec_mask == '0);
          route_mask = route_drop ? '0 : dec_mask;
        end
      end
      ST_FWD:  route_mask = mask_reg;
      ST_DROP: route_drop = 1'b1;
      default: ;
    endcase
    // Every masked output must have room so the beat lands on all of them at once.
    s_ready    = !rst && (route_drop ||
                 ((state != ST_IDLE || decide) && (&(out_ready | ~route_mask))));
    accept     = s_axis.tvalid && s_ready;
    load       = {M_COUNT{accept}} & route_mask;
    drop_pulse = accept && last_beat && route_drop;
    if (decide) begin
      mask_next  = route_mask;
      state_next = route_drop ? ST_DROP : ST_FWD;
    end
    if (accept && last_beat) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mask_reg  <= '0;
      stat_drop <= 1'b0;
    end else begin
      state     <= state_next;
      mask_reg  <= mask_next;
      stat_drop <= drop_pulse;
    end
  end

  assign busy          = (state != ST_IDLE);
  assign s_axis.tready = s_ready;

  for (genvar i = 0; i < M_COUNT; i++) begin : g_out
    logic [W-1:0] q;

    taxi_axis_demux_mcast_oreg #(.W(W)) u_oreg (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .din   (beat),
      .ready (m_axis[i].tready),
      .valid (out_valid[i]),
      .dout  (q)
    );

    assign out_ready[i]    = !out_valid[i] || m_axis[i].tready;
    assign m_axis[i].tvalid = out_valid[i];
    assign {m_axis[i].tdata, m_axis[i].tkeep, m_axis[i].tstrb, m_axis[i].tlast,
            m_axis[i].tid, m_axis[i].tuser, m_axis[i].tdest} = q;
  end

endmodule

// File: tb/tb_taxi_axis_demux_mcast.sv
// tb/tb_taxi_axis_demux_mcast.sv - self-checking bench for taxi_axis_demux_mcast
module tb_taxi_axis_demux_mcast;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] dest;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable, drop, s_valid, s_last, s_sel;
  logic [3:0] select_mask;
  logic [7:0] s_data;
  logic [9:0] s_dest;
  logic [7:0] rdy;
  wire  [1:0] stat, busy_o, s_rdy;
  wire  [7:0] vld;
  wire  [7:0] olast;
  wire  [7:0] odata [8];
  wire  [7:0] odest [8];

  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(8), .KEEP_W(1), .ID_W(8), .DEST_W(10), .USER_W(1)) sa ();
  taxi_axis_if #(.DATA_W(8), .KEEP_W(1), .ID_W(8), .DEST_W(10), .USER_W(1)) sb ();
  taxi_axis_if #(.DATA_W(8), .KEEP_W(1), .ID_W(8), .DEST_W(8), .USER_W(1)) ma [4] ();
  taxi_axis_if #(.DATA_W(8), .KEEP_W(1), .ID_W(8), .DEST_W(8), .USER_W(1)) mb [3] ();

  assign sa.tdata = s_data;  assign sa.tkeep = 1'b1; assign sa.tstrb = 1'b1;
  assign sa.tlast = s_last;  assign sa.tid = 8'h0;   assign sa.tuser = 1'b0;
  assign sa.tdest = s_dest;  assign sa.tvalid = s_valid && !s_sel;
  assign sb.tdata = s_data;  assign sb.tkeep = 1'b1; assign sb.tstrb = 1'b1;
  assign sb.tlast = s_last;  assign sb.tid = 8'h0;   assign sb.tuser = 1'b0;
  assign sb.tdest = s_dest;  assign sb.tvalid = s_valid && s_sel;
  assign s_rdy = {sb.tready, sa.tready};

  for (genvar i = 0; i < 4; i++) begin : g_ma
    assign ma[i].tready = rdy[i];
    assign vld[i]   = ma[i].tvalid;
    assign odata[i] = ma[i].tdata;
    assign olast[i] = ma[i].tlast;
    assign odest[i] = ma[i].tdest;
  end
  for (genvar i = 0; i < 3; i++) begin : g_mb
    assign mb[i].tready = rdy[4+i];
    assign vld[4+i]   = mb[i].tvalid;
    assign odata[4+i] = mb[i].tdata;
    assign olast[4+i] = mb[i].tlast;
    assign odest[4+i] = mb[i].tdest;
  end
  assign vld[7] = 1'b0; assign odata[7] = 8'h0; assign olast[7] = 1'b0; assign odest[7] = 8'h0;

  taxi_axis_demux_mcast #(.M_COUNT(4), .TDEST_ROUTE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .s_axis(sa), .m_axis(ma), .enable(enable), .drop(drop),
    .select_mask(select_mask), .stat_drop(stat[0]), .busy(busy_o[0]));

  taxi_axis_demux_mcast #(.M_COUNT(3), .TDEST_ROUTE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .s_axis(sb), .m_axis(mb), .enable(enable), .drop(drop),
    .select_mask(select_mask[2:0]), .stat_drop(stat[1]), .busy(busy_o[1]));

  int    errors = 0;
  int    checks = 0;
  beat_t expq [8][$];
  bit    in_frame [2];
  bit    exp_stat [2];
  logic [3:0] tgt [2];
  int    rx_cnt [8];
  int    stat_cnt [2];
  int    base_rx [8];
  int    base_stat [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Frame destinations straight from the routing rules, evaluated at the first beat.
  function automatic logic [3:0] route_of(input int d);
    int idx;
    if (drop) return 4'b0;
    if (d == 0) return select_mask;
    idx = int'(s_dest[9:8]);
    return (idx < 3) ? 4'(1 << idx) : 4'b0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        in_frame[d] = 1'b0;
        exp_stat[d] = 1'b0;
      end
      for (int k = 0; k < 8; k++) expq[k].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy%0d", d), 32'(busy_o[d]), 32'(in_frame[d]));
        chk($sformatf("stat_drop%0d", d), 32'(stat[d]), 32'(exp_stat[d]));
        if (stat[d]) stat_cnt[d]++;
        exp_stat[d] = 1'b0;
        if (s_valid && (int'(s_sel) == d) && s_rdy[d]) begin
          if (!in_frame[d]) tgt[d] = route_of(d);
          for (int i = 0; i < 4; i++)
            if (tgt[d][i]) expq[d*4+i].push_back('{s_data, s_last, s_dest[7:0]});
          if (s_last) begin
            in_frame[d] = 1'b0;
            exp_stat[d] = (tgt[d] == 4'b0);
          end else begin
            in_frame[d] = 1'b1;
          end
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (vld[k] && rdy[k]) begin
          rx_cnt[k]++;
          if (expq[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat out%0d: got %0h required none", k, odata[k]);
          end else begin
            beat_t b;
            b = expq[k].pop_front();
            chk($sformatf("beat_out%0d", k), {odata[k], olast[k], odest[k]}, 32'(b));
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l, output int waits);
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    waits = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      waits++;
      if (s_rdy[s_sel]) begin
        @(posedge clk); #1;
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got tready=0 required acceptance of %0h", d);
    s_valid = 1'b0;
  endtask

  task automatic frame(input int n, input logic [7:0] first, output int cyc);
    int w;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      send(first + 8'(8'h11 * k), (k == n - 1), w);
      cyc += w;
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < 8; k++) base_rx[k] = rx_cnt[k];
    base_stat = stat_cnt;
  endtask

  initial begin
    int cyc, w;
    enable = 1'b1; drop = 1'b0; select_mask = 4'b0;
    s_valid = 1'b1; s_last = 1'b1; s_sel = 1'b0; s_data = 8'h0; s_dest = 10'h0;
    rdy = 8'hFF;
    for (int k = 0; k < 8; k++) rx_cnt[k] = 0;
    stat_cnt[0] = 0; stat_cnt[1] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 32'(s_rdy), 32'h0);
    chk("rst_m_tvalid", 32'(vld), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_stat", 32'(stat), 32'h0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst = 1'b0;

    // 3-beat multicast to m0 and m2
    snap();
    select_mask = 4'b0101;
    frame(3, 8'h11, cyc);
    drain();
    chk("mc_cycles", 32'(cyc), 32'd3);
    chk("mc_rx0", 32'(rx_cnt[0] - base_rx[0]), 32'd3);
    chk("mc_rx2", 32'(rx_cnt[2] - base_rx[2]), 32'd3);
    chk("mc_rx1", 32'(rx_cnt[1] - base_rx[1]), 32'd0);
    chk("mc_rx3", 32'(rx_cnt[3] - base_rx[3]), 32'd0);

    // m2 stalls two cycles mid-frame
    snap();
    fork
      frame(3, 8'h11, cyc);
      begin
        @(posedge clk); #1;
        rdy[2] = 1'b0;
        @(negedge clk);
        chk("stall_tready_a", 32'(s_rdy[0]), 32'h0);
        chk("stall_m2_valid", 32'(vld[2]), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_tready_b", 32'(s_rdy[0]), 32'h0);
        @(posedge clk); #1;
        rdy[2] = 1'b1;
      end
    join
    drain();
    chk("stall_rx0", 32'(rx_cnt[0] - base_rx[0]), 32'd3);
    chk("stall_rx2", 32'(rx_cnt[2] - base_rx[2]), 32'd3);

    // mask=0 frame is dropped at full rate
    snap();
    select_mask = 4'b0;
    frame(4, 8'h40, cyc);
    drain();
    chk("mask0_cycles", 32'(cyc), 32'd4);
    chk("mask0_stat", 32'(stat_cnt[0] - base_stat[0]), 32'd1);

    // drop=1 at frame start; clearing it mid-frame changes nothing
    snap();
    select_mask = 4'b0101;
    drop = 1'b1;
    send(8'h50, 1'b0, w);
    cyc = w;
    drop = 1'b0;
    for (int k = 1; k < 4; k++) begin
      send(8'h50 + 8'(k), (k == 3), w);
      cyc += w;
    end
    drain();
    chk("drop_cycles", 32'(cyc), 32'd4);
    chk("drop_stat", 32'(stat_cnt[0] - base_stat[0]), 32'd1);
    chk("drop_rx0", 32'(rx_cnt[0] - base_rx[0]), 32'd0);

    // enable low holds the frame start
    snap();
    select_mask = 4'b0001;
    enable = 1'b0;
    s_data = 8'h77; s_last = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("en0_tready", 32'(s_rdy[0]), 32'h0);
      @(posedge clk); #1;
    end
    enable = 1'b1;
    @(negedge clk);
    chk("en1_tready", 32'(s_rdy[0]), 32'h1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain();
    chk("en_rx0", 32'(rx_cnt[0] - base_rx[0]), 32'd1);

    // select_mask change mid-frame is ignored
    snap();
    select_mask = 4'b0001;
    send(8'hA1, 1'b0, w);
    select_mask = 4'b0010;
    send(8'hA2, 1'b0, w);
    send(8'hA3, 1'b1, w);
    drain();
    chk("tog_rx0", 32'(rx_cnt[0] - base_rx[0]), 32'd3);
    chk("tog_rx1", 32'(rx_cnt[1] - base_rx[1]), 32'd0);

    // back-to-back one-beat frames, alternating single targets
    snap();
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      select_mask = k[0] ? 4'b0010 : 4'b0001;
      send(8'hC0 + 8'(k), 1'b1, w);
      cyc += w;
    end
    drain();
    chk("b2b_cycles", 32'(cyc), 32'd6);
    chk("b2b_rx0", 32'(rx_cnt[0] - base_rx[0]), 32'd3);
    chk("b2b_rx1", 32'(rx_cnt[1] - base_rx[1]), 32'd3);

    // reset mid-frame, then a clean frame
    select_mask = 4'b0101;
    send(8'hE0, 1'b0, w);
    send(8'hE1, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", 32'(vld), 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    @(posedge clk); #1;
    snap();
    select_mask = 4'b0010;
    frame(3, 8'h21, cyc);
    drain();
    chk("postrst_rx1", 32'(rx_cnt[1] - base_rx[1]), 32'd3);
    chk("postrst_rx0", 32'(rx_cnt[0] - base_rx[0]), 32'd0);

    // tdest routing on the 3-output instance
    snap();
    s_sel = 1'b1;
    s_dest = {2'd2, 8'hA5};
    frame(2, 8'h61, cyc);
    drain();
    chk("tdest_rx2", 32'(rx_cnt[6] - base_rx[6]), 32'd2);
    chk("tdest_rx0", 32'(rx_cnt[4] - base_rx[4]), 32'd0);
    chk("tdest_rx1", 32'(rx_cnt[5] - base_rx[5]), 32'd0);

    // index 3 is out of range for three outputs
    snap();
    s_dest = {2'd3, 8'h5A};
    frame(2, 8'h71, cyc);
    drain();
    chk("oor_cycles", 32'(cyc), 32'd2);
    chk("oor_stat", 32'(stat_cnt[1] - base_stat[1]), 32'd1);
    chk("oor_rx2", 32'(rx_cnt[6] - base_rx[6]), 32'd0);
    s_sel = 1'b0;

    for (int k = 0; k < 8; k++) chk($sformatf("q_empty%0d", k), 32'(expq[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
